crypto_cmd_ctrl: RTL and testbench

Command and sequencing stage directly downstream of the USB register bridge, in the `clk_sys` domain. It watches the host-written input memory image for a new command and snapshots plaintext and key. It drives them into the crypto core over a valid/ready handshake, then captures the ciphertext into the output memory image that the bridge returns to the host. It also drives the done flag that the bridge's master status read reports.

---
 rtl/crypto_cmd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_crypto_cmd_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_cmd_ctrl.sv
// Command/sequencing stage between the USB register bridge and the crypto core.
// Define CRYPTO_CYCLE_COUNT_EN to build the 32-bit cycle counter reported in output bytes 4-7.
module crypto_cmd_ctrl #(
    parameter int MEMORY_WIDTH   = 8,
    parameter int MEMORY_BYTES   = 1 << MEMORY_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic [MEMORY_BYTES*8-1:0] memory_input,
    output logic [MEMORY_BYTES*8-1:0] memory_output,
    output logic                      crypto_done_fetched,
    output logic [127:0]              pt_out,
    output logic [127:0]              key_out,
    output logic                      in_valid,
    input  logic                      in_ready,
    input  logic [127:0]              ct_in,
    input  logic                      out_valid,
    output logic                      out_ready
);

`ifdef CRYPTO_CYCLE_COUNT_EN
    localparam int CNT_W = 32;
`else
    localparam int CNT_W = 16;
`endif

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] CMD_ENCRYPT = 8'h01;
    localparam logic [7:0] ST_IDLE     = 8'h00;
    localparam logic [7:0] ST_DONE     = 8'h01;
    localparam logic [7:0] ST_BUSY     = 8'h02;
    localparam logic [7:0] ST_BADCMD   = 8'h81;
    localparam logic [7:0] ST_TIMEOUT  = 8'h82;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [7:0]       tag_sync_p0;
    logic [7:0]       tag_sync_p1;
    logic [7:0]       tag_prev_p2;
    logic [7:0]       last_seq;
    logic [7:0]       status;
    logic [127:0]     ct;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             new_cmd;
    logic             timeout_hit;
    logic [7:0]       cmd_byte;
    logic             unused_input;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cmd_byte     = memory_input[7:0];
    assign unused_input = ^{memory_input[MEMORY_BYTES*8-1:384], memory_input[127:16]};

    // Tag synchronizer (p0/p1) plus one extra stage (p2) for the stability check
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tag_sync_p0 <= '0;
            tag_sync_p1 <= '0;
            tag_prev_p2 <= '0;
        end else begin
            tag_sync_p0 <= memory_input[15:8];
            tag_sync_p1 <= tag_sync_p0;
            tag_prev_p2 <= tag_sync_p1;
        end
    end

    // A tag seen on two consecutive cycles is settled, so a half-written tag never fires
    assign new_cmd     = (tag_sync_p1 == tag_prev_p2) && (tag_sync_p1 != last_seq);
    assign cnt_next    = sat_inc(cnt);
    assign timeout_hit = (cnt_next >= TIMEOUT_LIMIT);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            last_seq            <= '0;
            status              <= ST_IDLE;
            ct                  <= '0;
            cnt                 <= '0;
            pt_out              <= '0;
            key_out             <= '0;
            in_valid            <= 1'b0;
            out_ready           <= 1'b0;
            crypto_done_fetched <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (new_cmd) begin
                        last_seq <= tag_sync_p1;
                        ct       <= '0;
                        cnt      <= '0;
                        if (cmd_byte != CMD_ENCRYPT) begin
                            status              <= ST_BADCMD;
                            crypto_done_fetched <= 1'b1;
                            state               <= S_DONE;
                        end else begin
                            status              <= ST_BUSY;
                            crypto_done_fetched <= 1'b0;
                            state               <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    pt_out   <= memory_input[255:128];
                    key_out  <= memory_input[383:256];
                    in_valid <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (in_valid && in_ready) begin
                        in_valid  <= 1'b0;
                        out_ready <= 1'b1;
                        cnt       <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt_next;
                    // A result arriving on the timeout cycle still counts as success
                    if (out_valid) begin
                        ct                  <= ct_in;
                        status              <= ST_DONE;
                        out_ready           <= 1'b0;
                        crypto_done_fetched <= 1'b1;
                        state               <= S_DONE;
                    end else if (timeout_hit) begin
                        ct                  <= '0;
                        status              <= ST_TIMEOUT;
                        out_ready           <= 1'b0;
                        crypto_done_fetched <= 1'b1;
                        state               <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        memory_output          = '0;
        memory_output[7:0]     = status;
        memory_output[15:8]    = last_seq;
`ifdef CRYPTO_CYCLE_COUNT_EN
        memory_output[63:32]   = cnt;
`endif
        memory_output[255:128] = ct;
    end

endmodule

// File: tb/tb_crypto_cmd_ctrl.sv
// Directed testbench for crypto_cmd_ctrl; the core is modelled by the tasks driving in_ready/out_valid.
`timescale 1ns/1ps
module tb_crypto_cmd_ctrl;

    localparam int MW = 8;
    localparam int MB = 1 << MW;
    localparam int TO = 20;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    // PT ^ KEY, worked byte by byte
    localparam logic [127:0] CT_A = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] CT_B = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] CT_C = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic              clk_sys = 1'b0;
    logic              rst_n = 1'b0;
    logic [MB*8-1:0]   memory_input = '0;
    logic [MB*8-1:0]   memory_output;
    logic              crypto_done_fetched;
    logic [127:0]      pt_out;
    logic [127:0]      key_out;
    logic              in_valid;
    logic              in_ready = 1'b0;
    logic [127:0]      ct_in = '0;
    logic              out_valid = 1'b0;
    logic              out_ready;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_sys = ~clk_sys;

    crypto_cmd_ctrl #(
        .MEMORY_WIDTH(MW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_sys(clk_sys),
        .rst_n(rst_n),
        .memory_input(memory_input),
        .memory_output(memory_output),
        .crypto_done_fetched(crypto_done_fetched),
        .pt_out(pt_out),
        .key_out(key_out),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ct_in(ct_in),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    function automatic logic [MB*8-1:0] build_img(input logic [7:0] st, input logic [7:0] tag,
                                                  input logic [31:0] cnt, input logic [127:0] ct);
        logic [MB*8-1:0] img;
        img = '0;
        img[7:0] = st;
        img[15:8] = tag;
`ifdef CRYPTO_CYCLE_COUNT_EN
        img[63:32] = cnt;
`endif
        img[255:128] = ct;
        return img;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_cmd(input logic [7:0] cmd, input logic [127:0] pt, input logic [127:0] key);
        memory_input[7:0] = cmd;
        memory_input[255:128] = pt;
        memory_input[383:256] = key;
    endtask

    task automatic set_tag(input logic [7:0] t);
        memory_input[15:8] = t;
    endtask

    task automatic wait_in_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (memory_output !== '0) begin
            tests_failed++;
            $display("FAIL reset_image got %h want 0", memory_output[383:0]);
        end
        tests_run++;
        if ({crypto_done_fetched, in_valid, out_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 000", {crypto_done_fetched, in_valid, out_ready});
        end
        tests_run++;
        if ({pt_out, key_out} !== 256'h0) begin
            tests_failed++;
            $display("FAIL reset_operands got %h want 0", {pt_out, key_out});
        end
        rst_n = 1'b1;
        in_ready = 1'b1;
        set_cmd(8'h01, PT, KEY);
        set_tag(8'h00);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (in_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL tag0_no_cmd got in_valid=1 want 0");
        end
        tests_run++;
        if (memory_output[7:0] !== 8'h00) begin
            tests_failed++;
            $display("FAIL tag0_status got %h want 00", memory_output[7:0]);
        end
    endtask

    task automatic test_encrypt();
        bit seen;
        logic [MB*8-1:0] exp;
        in_ready = 1'b1;
        set_cmd(8'h01, PT, KEY);
        set_tag(8'h05);
        wait_in_valid(seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL enc_in_valid got 0 want 1");
        end
        tests_run++;
        if ({pt_out, key_out} !== {PT, KEY}) begin
            tests_failed++;
            $display("FAIL enc_operands got %h %h want %h %h", pt_out, key_out, PT, KEY);
        end
        tick();
        tests_run++;
        if ({in_valid, out_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL enc_handshake got in_valid,out_ready=%b want 01", {in_valid, out_ready});
        end
        repeat (9) tick();
        tests_run++;
        if ({memory_output[7:0], crypto_done_fetched} !== {8'h02, 1'b0}) begin
            tests_failed++;
            $display("FAIL enc_busy got st=%h done=%b want st=02 done=0", memory_output[7:0], crypto_done_fetched);
        end
        out_valid = 1'b1;
        ct_in = CT_A;
        tick();
        out_valid = 1'b0;
        ct_in = '0;
        exp = build_img(8'h01, 8'h05, 32'd10, CT_A);
        tests_run++;
        if (memory_output !== exp) begin
            tests_failed++;
            $display("FAIL enc_image got %h want %h", memory_output[383:0], exp[383:0]);
        end
        tests_run++;
        if ({crypto_done_fetched, out_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL enc_done got done,out_ready=%b want 10", {crypto_done_fetched, out_ready});
        end
    endtask

    task automatic test_bad_cmd();
        bit seen_iv;
        bit found;
        logic [MB*8-1:0] exp;
        set_cmd(8'h03, PT, KEY);
        set_tag(8'h06);
        seen_iv = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_valid === 1'b1) seen_iv = 1'b1;
            if (memory_output[7:0] === 8'h81) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL bad_status got %h want 81", memory_output[7:0]);
        end
        tests_run++;
        if (seen_iv !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_no_in_valid got 1 want 0");
        end
        exp = build_img(8'h81, 8'h06, 32'd0, 128'h0);
        tests_run++;
        if (memory_output !== exp || crypto_done_fetched !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_image got %h done=%b want %h done=1", memory_output[383:0], crypto_done_fetched, exp[383:0]);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        logic [MB*8-1:0] exp;
        in_ready = 1'b1;
        set_cmd(8'h01, PT, KEY);
        set_tag(8'h09);
        wait_in_valid(seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL to_in_valid got 0 want 1");
        end
        tick();
        repeat (19) tick();
        tests_run++;
        if ({memory_output[7:0], crypto_done_fetched, out_ready} !== {8'h02, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL to_cycle20 got st=%h done=%b ordy=%b want st=02 done=0 ordy=1",
                     memory_output[7:0], crypto_done_fetched, out_ready);
        end
        tick();
        exp = build_img(8'h82, 8'h09, 32'd20, 128'h0);
        tests_run++;
        if (memory_output !== exp) begin
            tests_failed++;
            $display("FAIL to_image got %h want %h", memory_output[383:0], exp[383:0]);
        end
        tests_run++;
        if ({crypto_done_fetched, out_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL to_done got done,out_ready=%b want 10", {crypto_done_fetched, out_ready});
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [MB*8-1:0] exp;
        in_ready = 1'b1;
        set_cmd(8'h01, PT, KEY);
        set_tag(8'h07);
        wait_in_valid(seen);
        tick();
        set_tag(8'h08);
        repeat (4) tick();
        out_valid = 1'b1;
        ct_in = CT_B;
        tick();
        out_valid = 1'b0;
        ct_in = '0;
        exp = build_img(8'h01, 8'h07, 32'd5, CT_B);
        tests_run++;
        if (memory_output !== exp || crypto_done_fetched !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first got %h done=%b want %h done=1", memory_output[383:0], crypto_done_fetched, exp[383:0]);
        end
        wait_in_valid(seen);
        tests_run++;
        if (!seen || crypto_done_fetched !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_pending got in_valid=%b done=%b want 1 0", seen, crypto_done_fetched);
        end
        tick();
        repeat (2) tick();
        out_valid = 1'b1;
        ct_in = CT_C;
        tick();
        out_valid = 1'b0;
        ct_in = '0;
        exp = build_img(8'h01, 8'h08, 32'd3, CT_C);
        tests_run++;
        if (memory_output !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second got %h want %h", memory_output[383:0], exp[383:0]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [MB*8-1:0] exp;
        in_ready = 1'b0;
        set_cmd(8'h01, PT, KEY);
        set_tag(8'h0a);
        wait_in_valid(seen);
        repeat (2) tick();
        tests_run++;
        if (in_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_hold got in_valid=%b want 1", in_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_valid, out_ready, crypto_done_fetched} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_async got iv,ordy,done=%b want 000", {in_valid, out_ready, crypto_done_fetched});
        end
        tests_run++;
        if (memory_output !== '0) begin
            tests_failed++;
            $display("FAIL mid_image got %h want 0", memory_output[383:0]);
        end
        set_tag(8'h0b);
        repeat (2) tick();
        rst_n = 1'b1;
        in_ready = 1'b1;
        wait_in_valid(seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL mid_restart got in_valid=0 want 1");
        end
        tick();
        tick();
        out_valid = 1'b1;
        ct_in = CT_A;
        tick();
        out_valid = 1'b0;
        ct_in = '0;
        exp = build_img(8'h01, 8'h0b, 32'd2, CT_A);
        tests_run++;
        if (memory_output !== exp) begin
            tests_failed++;
            $display("FAIL mid_result got %h want %h", memory_output[383:0], exp[383:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_bad_cmd();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
